fetch_decode: RTL and testbench
===============================

// Module: fetch_decode
// PURPOSE
//  Supplies ctrl with its inputs: holds PC, instruction register (IR) and status register (stat).
//  Fetches 32-bit instructions from instruction memory over a req/ack handshake and splits IR into fields.
//  Resolves branch conditions from IR and stat, and applies PC redirects when ctrl commands them.
//  Sits between imem and ctrl/rf/alu in the SISC datapath.
// PARAMETERS
//  ADDR_W   16  PC / imem address width
//  INSTR_W  32  instruction width (field positions below assume 32)
//  TIMEOUT  15  ack-wait limit in cycles (used only with FETCH_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_f       in   1       asynchronous, active-low reset
//  fetch_go    in   1       ctrl pulse: start fetch at PC
//  imem_req    out  1       read request to imem
//  imem_addr   out  ADDR_W  = PC while fetching
//  imem_ack    in   1       imem data valid this cycle
//  imem_rdata  in   INSTR_W instruction word
//  pc_write    in   1       ctrl: apply branch redirect if br_taken
//  stat_en     in   1       load stat from stat_in
//  stat_in     in   4       {C,N,V,Z} from alu
//  opcode      out  4       IR[31:28]
//  mm          out  4       IR[27:24]
//  rd/rs/rt    out  4 each  IR[23:20] / IR[19:16] / IR[15:12]
//  imm         out  16      IR[15:0]
//  stat        out  4       status register
//  br_taken    out  1       combinational branch decision
//  pc          out  ADDR_W  current PC
//  fetch_busy  out  1       high in REQ state
//  fetch_err   out  1       timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (async, rst_f=0): pc=0, IR=0 (NOOP, all fields 0), stat=0, state=IDLE, imem_req=0, fetch_err=0.
//  FSM states: IDLE, REQ.
//   IDLE: fetch_go -> REQ next cycle.
//   REQ:  imem_req=1, imem_addr=pc.
//         On imem_ack: IR<=imem_rdata, pc<=pc+1 (wraps mod 2^ADDR_W), -> IDLE.
//         Same-cycle ack allowed, giving minimum latency fetch_go->IR valid of 2 edges.
//  fetch_go while in REQ is ignored.
//  Branch decode, from IR and stat: t=(mm & stat)!=0.
//   BRA(4)/BRR(5): br_taken = t.   BNE(6)/BNR(7): br_taken = !t.   All other opcodes: br_taken = 0.
//  pc_write, in IDLE, with br_taken:
//   BRA/BNE: pc <= imm[ADDR_W-1:0].
//   BRR/BNR: pc <= pc + sext(imm), wrapping.
//  pc_write with br_taken=0: no change. pc_write in REQ: ignored (PC is frozen during a fetch).
//  stat_en: stat<=stat_in in any state; independent of fetch; stat_en and pc_write in the same cycle
//   -> the branch uses the OLD stat.
//  Reset mid-fetch: imem_req drops asynchronously; a late ack after reset is ignored (state=IDLE).
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   REQ counts cycles without ack; at TIMEOUT, IR<=32'hF000_0000 (HLT), fetch_err<=1 (sticky until reset),
//   pc unchanged, -> IDLE.
//  Undefined: REQ waits forever; fetch_err is constant 0; no counter is built.
// STRUCTURE
//  Shared package/header sisc_defs: opcode constants (NOOP..HLT), IR field bit positions, stat bit order {C,N,V,Z}.
//  One natural sub-module: br_cond (combinational opcode/mm/stat -> br_taken), reusable by ctrl.
//  The PC, IR, stat and FSM stay in this module.
// TESTING
//  1. Reset, then fetch_go with ack 1 cycle later, rdata=32'h8000_0000 -> opcode=8, pc=1, imem_req low after ack.
//  2. IR=BRA mm=4'b0001, stat=4'b0001, pc_write -> pc=imm. Repeat with stat=0 -> pc unchanged.
//  3. pc=16'h0010, IR=BRR imm=16'hFFFE, taken -> pc=16'h000E. pc=16'hFFFF, fetch -> pc=0 (wrap).
//  4. BNE mm=0, any stat -> br_taken=1. stat_en and pc_write in the same cycle -> decision uses old stat.
//  5. rst_f low during REQ -> imem_req=0 immediately; ack afterwards leaves IR=0 and pc=0.
//  6. FETCH_TIMEOUT_EN, no ack for 15 cycles -> opcode=15, fetch_err=1, pc unchanged.
//     Without the macro -> still in REQ after 100 cycles.

Source files
------------

// File: rtl/sisc_defs_pkg.sv
// Shared SISC definitions: opcode encodings, IR field layout and status bit order.
// Imported by fetch_decode and fetch_decode_br_cond (and reusable by ctrl).
package sisc_defs_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned STAT_W = 4;
    localparam int unsigned IR_W   = 32;

    // IR field bit positions (MSB of each field)
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned MM_MSB  = 27;
    localparam int unsigned RD_MSB  = 23;
    localparam int unsigned RS_MSB  = 19;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned IMM_MSB = 15;

    // stat bit order {C,N,V,Z}
    localparam int unsigned STAT_C = 3;
    localparam int unsigned STAT_N = 2;
    localparam int unsigned STAT_V = 1;
    localparam int unsigned STAT_Z = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOOP  = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_LOGIC = 4'h3,
        OP_BRA   = 4'h4,
        OP_BRR   = 4'h5,
        OP_BNE   = 4'h6,
        OP_BNR   = 4'h7,
        OP_LOD   = 4'h8,
        OP_STR   = 4'h9,
        OP_SHIFT = 4'hA,
        OP_HLT   = 4'hF
    } opcode_e;

    // Instruction register layout; rt aliases imm[15:12]
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [3:0]       mm;
        logic [3:0]       rd;
        logic [3:0]       rs;
        logic [IMM_W-1:0] imm;
    } ir_t;

    localparam logic [IR_W-1:0] HLT_WORD = {OP_HLT, 28'h000_0000};

    // Relative branches (BRR/BNR) add sext(imm) to pc; others load imm
    function automatic logic is_rel_branch(input logic [OPC_W-1:0] op);
        return (op == OP_BRR) || (op == OP_BNR);
    endfunction

endpackage

// File: rtl/fetch_decode_br_cond.sv
// Branch condition resolver (br_cond): combinational opcode/mm/stat -> br_taken.
// Ports: opcode, mm, stat in; br_taken out.
// t = (mm & stat) != 0; BRA/BRR take on t, BNE/BNR take on !t, all else never.
module fetch_decode_br_cond
    import sisc_defs_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [3:0]        mm,
    input  logic [STAT_W-1:0] stat,
    output logic              br_taken
);

    logic t_c;

    assign t_c = |(mm & stat);

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: br_taken = t_c;
            OP_BNE, OP_BNR: br_taken = !t_c;
            default:        br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// SISC fetch/decode: holds PC, IR and stat; fetches from imem via req/ack;
// splits IR into fields; resolves and applies branch redirects.
// Ports: clk, rst_f (async active-low); fetch_go; imem_req/addr/ack/rdata;
//        pc_write; stat_en/stat_in; opcode/mm/rd/rs/rt/imm; stat; br_taken (comb);
//        pc; fetch_busy; fetch_err.
// Optional: FETCH_TIMEOUT_EN adds an ack-wait limit (TIMEOUT cycles) that loads
//           HLT and sets a sticky fetch_err; without it fetch_err is tied 0.
module fetch_decode
    import sisc_defs_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 32
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_go,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               pc_write,
    input  logic               stat_en,
    input  logic [STAT_W-1:0]  stat_in,
    output logic [OPC_W-1:0]   opcode,
    output logic [3:0]         mm,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [IMM_W-1:0]   imm,
    output logic [STAT_W-1:0]  stat,
    output logic               br_taken,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_busy,
    output logic               fetch_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    ir_t                 ir_q, ir_d;
    logic [STAT_W-1:0]   stat_q, stat_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    fetch_decode_br_cond u_br_cond (
        .opcode   (ir_q.opcode),
        .mm       (ir_q.mm),
        .stat     (stat_q),
        .br_taken (br_taken)
    );

    // Next-state logic for FSM, PC, IR and stat
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        stat_d  = stat_en ? stat_in : stat_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fetch_go) begin
                    state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                // Branch sees the stat register value before any same-cycle stat_en load
                if (pc_write && br_taken) begin
                    if (is_rel_branch(ir_q.opcode))
                        pc_d = pc_q + ADDR_W'(signed'(ir_q.imm));
                    else
                        pc_d = ADDR_W'(ir_q.imm);
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    ir_d    = ir_t'(32'(imem_rdata));
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ir_d    = ir_t'(HLT_WORD);
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            stat_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            stat_q  <= stat_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign imem_req   = (state_q == ST_REQ);
    assign fetch_busy = (state_q == ST_REQ);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign stat       = stat_q;
    assign opcode     = ir_q.opcode;
    assign mm         = ir_q.mm;
    assign rd         = ir_q.rd;
    assign rs         = ir_q.rs;
    assign rt         = ir_q.imm[IMM_W-1 -: 4];
    assign imm        = ir_q.imm;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = err_q;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode. Inputs change and outputs are
// checked just after the falling clock edge.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_go;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_write;
    logic        stat_en;
    logic [3:0]  stat_in;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic [3:0]  stat;
    logic        br_taken;
    logic [15:0] pc;
    logic        fetch_busy;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_decode dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_go   (fetch_go),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_write   (pc_write),
        .stat_en    (stat_en),
        .stat_in    (stat_in),
        .opcode     (opcode),
        .mm         (mm),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .stat       (stat),
        .br_taken   (br_taken),
        .pc         (pc),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // fetch_go now, ack with word on the next cycle; ends one negedge after the ack edge
    task automatic do_fetch(input logic [31:0] word);
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic load_stat(input logic [3:0] s);
        stat_en = 1'b1;
        stat_in = s;
        @(negedge clk);
        stat_en = 1'b0;
    endtask

    task automatic pulse_pc_write();
        pc_write = 1'b1;
        @(negedge clk);
        pc_write = 1'b0;
    endtask

    initial begin
        rst_f = 1'b0; fetch_go = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        pc_write = 1'b0; stat_en = 1'b0; stat_in = 4'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_pc",     32'(pc), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_imm",    32'(imm), 0);
        check("rst_stat",   32'(stat), 0);
        check("rst_req",    32'(imem_req), 0);
        check("rst_err",    32'(fetch_err), 0);
        rst_f = 1'b1;
        @(negedge clk);

        // 1: basic fetch, ack one cycle after fetch_go
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go = 1'b0;
        check("f1_req",  32'(imem_req), 1);
        check("f1_busy", 32'(fetch_busy), 1);
        check("f1_addr", 32'(imem_addr), 0);
        imem_ack = 1'b1; imem_rdata = 32'h8000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("f1_opcode", 32'(opcode), 8);
        check("f1_pc",     32'(pc), 1);
        check("f1_req_lo", 32'(imem_req), 0);
        check("f1_nobr",   32'(br_taken), 0);

        // Field split
        do_fetch(32'h9ABC_DEF0);
        check("fld_op",  32'(opcode), 9);
        check("fld_mm",  32'(mm), 4'hA);
        check("fld_rd",  32'(rd), 4'hB);
        check("fld_rs",  32'(rs), 4'hC);
        check("fld_rt",  32'(rt), 4'hD);
        check("fld_imm", 32'(imm), 16'hDEF0);
        check("fld_pc",  32'(pc), 2);

        // 2: BRA taken / not taken
        load_stat(4'b0001);
        check("stat_ld", 32'(stat), 1);
        do_fetch(32'h4100_1234);
        check("bra_taken", 32'(br_taken), 1);
        pulse_pc_write();
        check("bra_pc", 32'(pc), 16'h1234);
        load_stat(4'b0000);
        check("bra_nt", 32'(br_taken), 0);
        pulse_pc_write();
        check("bra_nt_pc", 32'(pc), 16'h1234);

        // 3: BRR with negative offset from pc=0x0010
        load_stat(4'b0010);
        do_fetch(32'h4F00_000F);
        pulse_pc_write();
        check("brr_setup", 32'(pc), 16'h000F);
        do_fetch(32'h5F00_FFFE);
        check("brr_pc0", 32'(pc), 16'h0010);
        check("brr_taken", 32'(br_taken), 1);
        pulse_pc_write();
        check("brr_pc", 32'(pc), 16'h000E);

        // 3: pc wraps on fetch from 0xFFFF
        do_fetch(32'h4F00_FFFF);
        pulse_pc_write();
        check("wrap_setup", 32'(pc), 16'hFFFF);
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go = 1'b0;
        check("wrap_addr", 32'(imem_addr), 16'hFFFF);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("wrap_pc", 32'(pc), 0);

        // 4: BNE with mm=0 is always taken
        do_fetch(32'h6000_0000);
        check("bne_mm0_a", 32'(br_taken), 1);
        load_stat(4'hF);
        check("bne_mm0_b", 32'(br_taken), 1);
        pulse_pc_write();
        check("bne_mm0_pc", 32'(pc), 0);

        // 4: stat_en with pc_write in the same cycle uses old stat
        load_stat(4'b0000);
        do_fetch(32'h6100_0055);
        check("old_stat_br", 32'(br_taken), 1);
        stat_en = 1'b1; stat_in = 4'b0001; pc_write = 1'b1;
        @(negedge clk);
        stat_en = 1'b0; pc_write = 1'b0;
        check("old_stat_pc",   32'(pc), 16'h0055);
        check("old_stat_stat", 32'(stat), 1);
        check("old_stat_nt",   32'(br_taken), 0);
        stat_en = 1'b1; stat_in = 4'b0000; pc_write = 1'b1;
        @(negedge clk);
        stat_en = 1'b0; pc_write = 1'b0;
        check("old_stat_pc2", 32'(pc), 16'h0055);

        // BNR relative, taken when (mm & stat)==0
        load_stat(4'b0001);
        do_fetch(32'h7100_0003);
        check("bnr_nt", 32'(br_taken), 0);
        load_stat(4'b0000);
        check("bnr_t", 32'(br_taken), 1);
        pulse_pc_write();
        check("bnr_pc", 32'(pc), 16'h0059);

        // pc_write during REQ is ignored
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go = 1'b0; pc_write = 1'b1;
        @(negedge clk);
        pc_write = 1'b0;
        check("req_pcw_pc",  32'(pc), 16'h0059);
        check("req_pcw_req", 32'(imem_req), 1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("req_pcw_after", 32'(pc), 16'h005A);

        // 5: reset during REQ drops imem_req at once; late ack is ignored
        load_stat(4'b0101);
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go = 1'b0;
        check("mid_req", 32'(imem_req), 1);
        #2 rst_f = 1'b0;
        #1 check("mid_req_async", 32'(imem_req), 0);
        #1 rst_f = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("mid_ir",   32'(opcode), 0);
        check("mid_imm",  32'(imm), 0);
        check("mid_pc",   32'(pc), 0);
        check("mid_stat", 32'(stat), 0);
        check("mid_idle", 32'(imem_req), 0);

        // 6: no ack
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (14) @(negedge clk);
        check("to_wait_busy", 32'(fetch_busy), 1);
        check("to_wait_err",  32'(fetch_err), 0);
        @(negedge clk);
        check("to_opcode", 32'(opcode), 15);
        check("to_err",    32'(fetch_err), 1);
        check("to_pc",     32'(pc), 0);
        check("to_idle",   32'(imem_req), 0);
        do_fetch(32'h1000_0000);
        check("to_sticky", 32'(fetch_err), 1);
        check("to_pc2",    32'(pc), 1);
`else
        repeat (100) @(negedge clk);
        check("nto_req",  32'(imem_req), 1);
        check("nto_busy", 32'(fetch_busy), 1);
        check("nto_err",  32'(fetch_err), 0);
        check("nto_pc",   32'(pc), 0);
        imem_ack = 1'b1; imem_rdata = 32'h1000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("nto_late_ack", 32'(opcode), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
